// File: rtl/connect4_input_ctrl.sv
// Connect-4 button front end: sync, debounce, edge-detect, gated command pulses,
// plus an optional turn timer built only when CONNECT4_TURN_TIMER_EN is defined.
module connect4_input_ctrl #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int CLK_PER_SEC     = 50_000_000,
   parameter int TURN_SECONDS    = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_drop,
   input  logic [2:0] fsm_state,
   input  logic       win_flag,
   output logic       move_left,
   output logic       move_right,
   output logic       move_made,
   output logic       times_up,
   output logic [4:0] time_left
);

   localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [4:0]    TL_INIT  = 5'(TURN_SECONDS);

   // bit 0 = left, bit 1 = right, bit 2 = drop
   logic [2:0]    w_raw;
   logic [2:0]    r_sync1, r_sync2, r_deb, r_deb_d;
   logic [CW-1:0] r_cnt [3];
   logic [2:0]    w_req;
   logic          w_en;
   logic          w_left_nxt, w_right_nxt, w_made_nxt;
   logic          r_move_left, r_move_right, r_move_made;

   assign w_raw = {btn_drop, btn_right, btn_left};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_deb   <= '0;
         r_deb_d <= '0;
         for (int i = 0; i < 3; i++) r_cnt[i] <= '0;
      end else begin
         r_sync1 <= w_raw;
         r_sync2 <= r_sync1;
         r_deb_d <= r_deb;
         // any sample matching the current level restarts the stability count
         for (int i = 0; i < 3; i++) begin
            if (r_sync2[i] == r_deb[i]) begin
               r_cnt[i] <= '0;
            end else if (r_cnt[i] == CNT_LAST) begin
               r_cnt[i] <= '0;
               r_deb[i] <= ~r_deb[i];
            end else begin
               r_cnt[i] <= r_cnt[i] + CW'(1);
            end
         end
      end
   end

   assign w_req       = r_deb & ~r_deb_d;
   assign w_en        = (fsm_state == 3'd1) && !win_flag;
   assign w_made_nxt  = w_en & w_req[2];
   assign w_left_nxt  = w_en & w_req[0] & ~w_req[1] & ~w_req[2];
   assign w_right_nxt = w_en & w_req[1] & ~w_req[0] & ~w_req[2];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_move_left  <= 1'b0;
         r_move_right <= 1'b0;
         r_move_made  <= 1'b0;
      end else begin
         r_move_left  <= w_left_nxt;
         r_move_right <= w_right_nxt;
         r_move_made  <= w_made_nxt;
      end
   end

   assign move_left  = r_move_left;
   assign move_right = r_move_right;
   assign move_made  = r_move_made;

`ifdef CONNECT4_TURN_TIMER_EN
   localparam int            PW         = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_PER_SEC - 1);

   typedef enum logic [1:0] {T_IDLE, T_RUNNING, T_EXPIRED} tstate_t;

   tstate_t       r_tstate, w_tstate_nxt;
   logic [PW-1:0] r_presc, w_presc_nxt;
   logic [4:0]    r_tl, w_tl_nxt;
   logic          r_tu, w_tu_nxt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_tstate <= T_IDLE;
         r_presc  <= '0;
         r_tl     <= TL_INIT;
         r_tu     <= 1'b0;
      end else begin
         r_tstate <= w_tstate_nxt;
         r_presc  <= w_presc_nxt;
         r_tl     <= w_tl_nxt;
         r_tu     <= w_tu_nxt;
      end
   end

   // a move issued on the same edge as expiry ends the turn without times_up
   always_comb begin
      w_tstate_nxt = r_tstate;
      w_presc_nxt  = r_presc;
      w_tl_nxt     = r_tl;
      w_tu_nxt     = 1'b0;
      case (r_tstate)
         T_IDLE: begin
            w_tl_nxt = TL_INIT;
            if (w_en) begin
               w_tstate_nxt = T_RUNNING;
               w_presc_nxt  = '0;
            end
         end
         T_RUNNING: begin
            if (w_made_nxt || !w_en) begin
               w_tstate_nxt = T_IDLE;
               w_tl_nxt     = TL_INIT;
               w_presc_nxt  = '0;
            end else if (r_presc == PRESC_LAST) begin
               w_presc_nxt = '0;
               if (r_tl <= 5'd1) begin
                  w_tl_nxt     = 5'd0;
                  w_tu_nxt     = 1'b1;
                  w_tstate_nxt = T_EXPIRED;
               end else begin
                  w_tl_nxt = r_tl - 5'd1;
               end
            end else begin
               w_presc_nxt = r_presc + PW'(1);
            end
         end
         T_EXPIRED: begin
            w_tl_nxt = 5'd0;
            if (fsm_state != 3'd1) begin
               w_tstate_nxt = T_IDLE;
               w_tl_nxt     = TL_INIT;
            end
         end
         default: begin
            w_tstate_nxt = T_IDLE;
            w_tl_nxt     = TL_INIT;
         end
      endcase
   end

   assign times_up  = r_tu;
   assign time_left = r_tl;
`else
   assign times_up  = 1'b0;
   assign time_left = TL_INIT;
`endif

endmodule

// File: tb/tb_connect4_input_ctrl.sv
// Self-checking bench for connect4_input_ctrl: reset, vector table, hand-written
// timer/latency/reset sequences and random stimulus against a behavioural model.
module tb_connect4_input_ctrl;

   localparam int DB  = 4;
   localparam int CPS = 10;
   localparam int TS  = 3;
`ifdef CONNECT4_TURN_TIMER_EN
   localparam bit TEN = 1'b1;
`else
   localparam bit TEN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic       bl, br, bd;
   logic [2:0] fs;
   logic       wf;
   logic       move_left, move_right, move_made, times_up;
   logic [4:0] time_left;

   connect4_input_ctrl #(.DEBOUNCE_CYCLES(DB), .CLK_PER_SEC(CPS), .TURN_SECONDS(TS)) dut (
      .clk(clk), .reset(reset), .btn_left(bl), .btn_right(br), .btn_drop(bd),
      .fsm_state(fs), .win_flag(wf), .move_left(move_left), .move_right(move_right),
      .move_made(move_made), .times_up(times_up), .time_left(time_left));

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   int c_ml, c_mr, c_mm, c_tu;

   // behavioural model: sync is a 2-sample delay, a level flips once the last DB
   // synchronized samples all disagree with it, the timer is elapsed-cycles based
   logic [2:0] m_s1, m_s2, m_deb, m_debd;
   logic [2:0] m_hist[$];
   int         m_phase;     // 0 idle, 1 running, 2 expired
   int         m_elapsed;
   bit         e_ml, e_mr, e_mm, e_tu;
   int         e_tl;

   task automatic model_reset();
      m_s1 = '0; m_s2 = '0; m_deb = '0; m_debd = '0;
      m_hist.delete();
      m_phase = 0; m_elapsed = 0;
      e_ml = 0; e_mr = 0; e_mm = 0; e_tu = 0; e_tl = TS;
   endtask

   task automatic model_step();
      logic [2:0] req, deb_old;
      bit en, all;
      en = (fs == 3'd1) && !wf;
      req = m_deb & ~m_debd;
      e_mm = en && req[2];
      e_ml = en && req[0] && !req[1] && !req[2];
      e_mr = en && req[1] && !req[0] && !req[2];
      deb_old = m_deb;
      m_debd  = deb_old;
      m_hist.push_back(m_s2);
      if (m_hist.size() > DB) void'(m_hist.pop_front());
      for (int b = 0; b < 3; b++) begin
         if (m_hist.size() == DB) begin
            all = 1;
            foreach (m_hist[k]) if (m_hist[k][b] == deb_old[b]) all = 0;
            if (all) m_deb[b] = ~deb_old[b];
         end
      end
      m_s2 = m_s1;
      m_s1 = {bd, br, bl};
      e_tu = 0;
      if (TEN) begin
         if (m_phase == 0) begin
            if (en) begin m_phase = 1; m_elapsed = 0; e_tl = TS; end
         end else if (m_phase == 1) begin
            if (e_mm || !en) begin
               m_phase = 0; e_tl = TS;
            end else begin
               m_elapsed++;
               e_tl = TS - m_elapsed / CPS;
               if (e_tl <= 0) begin e_tl = 0; e_tu = 1; m_phase = 2; end
            end
         end else if (fs != 3'd1) begin
            m_phase = 0; e_tl = TS;
         end
      end
   endtask

   task automatic chk(input string nm, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nm, got, exp);
      end
   endtask

   // inputs are set at a negedge; one clock later the outputs are compared
   task automatic tick();
      logic [8:0] got, exp;
      model_step();
      @(posedge clk);
      @(negedge clk);
      got = {move_left, move_right, move_made, times_up, time_left};
      exp = {e_ml, e_mr, e_mm, e_tu, 5'(e_tl)};
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL cycle @%0t: got l/r/m/tu/tl=%b expected %b", $time, got, exp);
      end
      c_ml += int'(move_left); c_mr += int'(move_right);
      c_mm += int'(move_made); c_tu += int'(times_up);
   endtask

   task automatic clr_cnt();
      c_ml = 0; c_mr = 0; c_mm = 0; c_tu = 0;
   endtask

   typedef struct {
      bit l, r, d;
      logic [2:0] fs;
      bit wf;
      int hold;
      int el, er, em;
   } vec_t;

   vec_t tbl[9];

   initial begin
      int lat, tl10, tl11, tl21, tl31, tu_at;
      tbl[0] = '{0,0,1, 3'd1, 0, 20, 0,0,1};
      tbl[1] = '{1,0,0, 3'd1, 0, 20, 1,0,0};
      tbl[2] = '{0,1,0, 3'd1, 0, 20, 0,1,0};
      tbl[3] = '{0,1,0, 3'd2, 0, 20, 0,0,0};
      tbl[4] = '{0,0,1, 3'd1, 1, 20, 0,0,0};
      tbl[5] = '{1,1,0, 3'd1, 0, 20, 0,0,0};
      tbl[6] = '{1,0,1, 3'd1, 0, 20, 0,0,1};
      tbl[7] = '{0,0,1, 3'd1, 0,  3, 0,0,0};
      tbl[8] = '{0,0,1, 3'd1, 0,  4, 0,0,1};

      reset = 1'b1; bl = 0; br = 0; bd = 0; fs = 3'd0; wf = 0;
      #2 reset = 1'b0;
      #1;
      chk("rst_pulses", int'({move_left, move_right, move_made, times_up}), 0);
      chk("rst_time_left", int'(time_left), TS);
      model_reset();
      @(negedge clk); @(negedge clk);
      reset = 1'b1;

      foreach (tbl[i]) begin
         fs = tbl[i].fs; wf = tbl[i].wf;
         bl = tbl[i].l; br = tbl[i].r; bd = tbl[i].d;
         clr_cnt();
         repeat (tbl[i].hold) tick();
         bl = 0; br = 0; bd = 0;
         repeat (14) tick();
         chk($sformatf("vec%0d_left", i), c_ml, tbl[i].el);
         chk($sformatf("vec%0d_right", i), c_mr, tbl[i].er);
         chk($sformatf("vec%0d_made", i), c_mm, tbl[i].em);
      end

      // drop latency and no-repeat while held
      fs = 3'd1; wf = 0; bd = 1; lat = -1; clr_cnt();
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (move_made && lat < 0) lat = i;
      end
      chk("drop_latency", lat, 7);
      chk("drop_held_count", c_mm, 1);
      bd = 0; repeat (12) tick();

      // bouncing left never settles
      clr_cnt();
      for (int i = 0; i < 20; i++) begin bl = ((i / 2) % 2 == 0); tick(); end
      bl = 0; repeat (10) tick();
      chk("bounce_left", c_ml, 0);

      // full turn expiry
      fs = 3'd0; repeat (3) tick();
      fs = 3'd1; clr_cnt(); tu_at = -1; tl10 = 0; tl11 = 0; tl21 = 0; tl31 = 0;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (i == 10) tl10 = time_left;
         if (i == 11) tl11 = time_left;
         if (i == 21) tl21 = time_left;
         if (i == 31) tl31 = time_left;
         if (times_up && tu_at < 0) tu_at = i;
      end
      chk("tl_sec3", tl10, TS);
      chk("tl_sec2", tl11, TEN ? 2 : TS);
      chk("tl_sec1", tl21, TEN ? 1 : TS);
      chk("tl_sec0", tl31, TEN ? 0 : TS);
      chk("times_up_count", c_tu, TEN ? 1 : 0);
      chk("times_up_cycle", tu_at, TEN ? 31 : -1);
      chk("expired_holds", int'(time_left), TEN ? 0 : TS);
      fs = 3'd2; tick();
      chk("expired_to_idle", int'(time_left), TS);

      // move issued on the expiry edge suppresses times_up
      fs = 3'd0; repeat (2) tick();
      fs = 3'd1; clr_cnt();
      repeat (24) tick();
      bd = 1;
      repeat (7) tick();
      chk("race_made", int'(move_made), 1);
      chk("race_tl", int'(time_left), TS);
      repeat (14) tick();
      chk("race_no_tu", c_tu, 0);
      bd = 0;
      chk("mid_turn_tl", int'(time_left), TEN ? 2 : TS);
      fs = 3'd2; tick();
      fs = 3'd1; tick();
      chk("reload_tl", int'(time_left), TS);
      repeat (10) tick();

      // reset mid-turn at time_left==1 with a left press mid-debounce
      fs = 3'd0; repeat (2) tick();
      fs = 3'd1;
      repeat (22) tick();
      bl = 1;
      repeat (2) tick();
      chk("pre_reset_tl", int'(time_left), TEN ? 1 : TS);
      #2 reset = 1'b0;
      #1;
      chk("rst_mid_pulses", int'({move_left, move_right, move_made, times_up}), 0);
      chk("rst_mid_tl", int'(time_left), TS);
      model_reset();
      @(posedge clk); @(posedge clk); @(negedge clk);
      reset = 1'b1; bl = 0; clr_cnt();
      repeat (30) tick();
      chk("post_rst_no_tu", c_tu, 0);
      chk("post_rst_no_left", c_ml, 0);
      tick();
      chk("post_rst_full_turn_tu", c_tu, TEN ? 1 : 0);

      // random stimulus against the model
      fs = 3'd1; wf = 0;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(9) == 0) bl = ~bl;
         if ($urandom_range(9) == 0) br = ~br;
         if ($urandom_range(9) == 0) bd = ~bd;
         if ($urandom_range(49) == 0) begin
            case ($urandom_range(5))
               0: fs = 3'd0;
               1: fs = 3'd2;
               2: fs = 3'd3;
               default: fs = 3'd1;
            endcase
         end
         if (!wf && $urandom_range(59) == 0) wf = 1;
         else if (wf && $urandom_range(7) == 0) wf = 0;
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
